i2s_transmitter: RTL and testbench

//  Sink for the effect chain output stream (audio_out/audio_out_valid). Buffers mono samples in a small FIFO.

---
 rtl/audio_pkg.sv | 15 +
 rtl/sample_fifo.sv | 55 +++++
 rtl/i2s_transmitter.sv | 183 ++++++++++++++++++
 tb/tb_i2s_transmitter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S output path.
//   i2s_state_t     : transmitter FSM state (IDLE until the FIFO is half full, then RUN)
//   I2S_FRAME_BITS  : BCLK periods per stereo frame
//   I2S_SLOT_BITS   : BCLK periods per channel slot
package audio_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2s_state_t;

  localparam int unsigned I2S_FRAME_BITS = 64;
  localparam int unsigned I2S_SLOT_BITS  = 32;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with asynchronous active-high reset.
//   clk_i, rst_i      : clock, async reset (pointers and level cleared, contents lost)
//   push_i, wdata_i   : write request and data; accepted when not full, or when full with a pop
//   pop_i, rdata_o    : read request and combinational head data; ignored when empty
//   full_o, empty_o   : occupancy flags
//   level_o           : current occupancy, 0..Depth
module sample_fifo #(
  parameter int unsigned Width = 24,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   level_q;
  logic [Width-1:0] mem_q [Depth];
  logic            do_push, do_pop;

  assign full_o  = (level_q == (PtrW+1)'(Depth));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S transmitter: buffers mono samples and sends each one on both L and R slots.
//   clk, rst        : system clock, async active-high reset
//   sample_valid    : 1-cycle strobe qualifying audio_in
//   audio_in        : signed sample; the top SAMPLE_BITS bits are transmitted
//   i2s_bclk        : bit clock, period 2*BCLK_DIV clk
//   i2s_lrclk       : word select, 0 = left, 1 = right
//   i2s_sdata       : serial data, MSB first with the standard one-bit delay
//   fifo_level      : sample FIFO occupancy
//   overflow        : 1-cycle pulse when a push is dropped on a full FIFO
//   underrun        : 1-cycle pulse when a frame starts in RUN with the FIFO empty
//   underrun_count  : (only with I2S_TX_UNDERRUN_CNT_EN) saturating count of underrun pulses
// Build option: define I2S_TX_UNDERRUN_CNT_EN to add the underrun_count port and counter.
module i2s_transmitter
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SAMPLE_BITS = 24,
  parameter int unsigned BCLK_DIV    = 4,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic [DATA_WIDTH-1:0]         audio_in,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_count
`endif
);

  localparam int unsigned CntW  = $clog2(BCLK_DIV);
  localparam int unsigned BitcW = $clog2(I2S_FRAME_BITS);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   bclk_q, bclk_d;
  logic [BitcW-1:0]       bitc_q, bitc_d;
  logic                   lrclk_q, lrclk_d;
  logic                   sdata_q, sdata_d;
  logic [SAMPLE_BITS-1:0] shreg_q, shreg_d;
  i2s_state_t             state_q, state_d;
  logic                   overflow_q, overflow_d;
  logic                   underrun_q, underrun_d;

  logic                   cnt_wrap, bclk_fall, frame_start;
  logic                   pop;
  logic [SAMPLE_BITS-1:0] fifo_head;
  logic                   fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_lvl;

  // Only the top SAMPLE_BITS bits of each sample are ever transmitted.
  if (DATA_WIDTH > SAMPLE_BITS) begin : g_drop_lsbs
    logic unused_lsbs;
    assign unused_lsbs = ^audio_in[DATA_WIDTH-SAMPLE_BITS-1:0];
  end

  sample_fifo #(
    .Width (SAMPLE_BITS),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (sample_valid),
    .wdata_i (audio_in[DATA_WIDTH-1 -: SAMPLE_BITS]),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  assign cnt_wrap    = (cnt_q == CntW'(BCLK_DIV - 1));
  assign bclk_fall   = cnt_wrap & bclk_q;
  assign frame_start = bclk_fall & (bitc_q == BitcW'(I2S_FRAME_BITS - 1));

  always_comb begin
    cnt_d  = cnt_wrap ? '0 : cnt_q + 1'b1;
    bclk_d = cnt_wrap ? ~bclk_q : bclk_q;
    bitc_d = bclk_fall ? bitc_q + 1'b1 : bitc_q;
  end

  // Frame-start sample selection; the latched word serves both slots of the frame.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    underrun_d = 1'b0;
    if (frame_start) begin
      unique case (state_q)
        IDLE: begin
          if (32'(fifo_lvl) >= FIFO_DEPTH / 2) begin
            state_d = RUN;
            pop     = 1'b1;
            shreg_d = fifo_head;
          end else begin
            shreg_d = '0;
          end
        end
        RUN: begin
          // A push landing in this same cycle is not visible yet: still an underrun.
          if (fifo_empty) begin
            shreg_d    = '0;
            underrun_d = 1'b1;
          end else begin
            pop     = 1'b1;
            shreg_d = fifo_head;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Serial outputs follow the post-fall bit index; slot bit k carries word bit SAMPLE_BITS-k.
  logic [I2S_SLOT_BITS-1:0] word_pad;
  int unsigned              k;
  logic [4:0]               sel;

  always_comb begin
    lrclk_d  = lrclk_q;
    sdata_d  = sdata_q;
    word_pad = I2S_SLOT_BITS'(shreg_d);
    k        = 32'(bitc_d[4:0]);
    sel      = 5'(SAMPLE_BITS - k);
    if (bclk_fall) begin
      lrclk_d = bitc_d[5];
      sdata_d = (k >= 1 && k <= SAMPLE_BITS) ? word_pad[sel] : 1'b0;
    end
  end

  assign overflow_d = sample_valid & fifo_full & ~pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      bclk_q     <= 1'b0;
      bitc_q     <= '0;
      lrclk_q    <= 1'b0;
      sdata_q    <= 1'b0;
      shreg_q    <= '0;
      state_q    <= IDLE;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bclk_q     <= bclk_d;
      bitc_q     <= bitc_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      shreg_q    <= shreg_d;
      state_q    <= state_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign i2s_bclk   = bclk_q;
  assign i2s_lrclk  = lrclk_q;
  assign i2s_sdata  = sdata_q;
  assign fifo_level = fifo_lvl;
  assign overflow   = overflow_q;
  assign underrun   = underrun_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_count_q <= '0;
    end else if (underrun_d && underrun_count_q != 16'hFFFF) begin
      underrun_count_q <= underrun_count_q + 16'd1;
    end
  end

  assign underrun_count = underrun_count_q;
`endif

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed self-checking bench for i2s_transmitter (SAMPLE_BITS=24, BCLK_DIV=4, FIFO_DEPTH=8).
module tb_i2s_transmitter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [31:0] audio_in = '0;
  logic        i2s_bclk, i2s_lrclk, i2s_sdata;
  logic [3:0]  fifo_level;
  logic        overflow, underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] frame_bits;
  logic        fs_underrun, ur_after;
  logic [3:0]  fs_level;

  i2s_transmitter #(
    .DATA_WIDTH  (32),
    .SAMPLE_BITS (24),
    .BCLK_DIV    (4),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .audio_in     (audio_in),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .underrun     (underrun)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count (underrun_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // sel 0: bclk rise, 1: lrclk rise, 2: lrclk fall. n counts sampled negedges.
  task automatic wait_edge(input int sel, input int limit, output int n, output bit found);
    logic a, b;
    n = 0;
    found = 1'b0;
    while (!found && n < limit) begin
      a = (sel == 0) ? i2s_bclk : i2s_lrclk;
      tick();
      n++;
      b = (sel == 0) ? i2s_bclk : i2s_lrclk;
      found = (sel == 2) ? (a && !b) : (!a && b);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    sample_valid = 1'b1;
    audio_in = d;
    tick();
    sample_valid = 1'b0;
  endtask

  // Waits for the next frame start, then samples sdata on each of the 64 bclk rises.
  task automatic capture_frame(input string tag);
    int  n;
    bit  found;
    wait_edge(2, 1200, n, found);
    check({tag, "_fs_timeout"}, 32'(found), 32'd1);
    fs_underrun = underrun;
    fs_level    = fifo_level;
    tick();
    ur_after = underrun;
    for (int i = 0; i < 64; i++) begin
      wait_edge(0, 20, n, found);
      if (!found) begin
        check({tag, "_bclk_timeout"}, 32'(found), 32'd1);
        break;
      end
      frame_bits[i] = i2s_sdata;
    end
  endtask

  task automatic check_frame(input string tag, input logic [23:0] exp);
    logic [23:0] l, r;
    logic        pad;
    pad = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      l[24-k] = frame_bits[k];
      r[24-k] = frame_bits[32+k];
    end
    pad = frame_bits[0] | frame_bits[32];
    for (int k = 25; k < 32; k++) pad = pad | frame_bits[k] | frame_bits[32+k];
    check({tag, "_left"}, 32'(l), 32'(exp));
    check({tag, "_right"}, 32'(r), 32'(exp));
    check({tag, "_pad"}, 32'(pad), 32'd0);
  endtask

  initial begin
    int  n;
    bit  found;

    // 1. Reset and idle clocking.
    tick();
    check("rst_outputs", {26'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun, 1'b0},
          32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    do_reset();
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("rst_ucount", 32'(underrun_count), 32'd0);
`endif
    wait_edge(0, 40, n, found);
    wait_edge(0, 40, n, found);
    check("bclk_period", 32'(n), 32'd8);
    wait_edge(1, 1200, n, found);
    wait_edge(1, 1200, n, found);
    check("lrclk_period", 32'(n), 32'd512);
    capture_frame("idle");
    check("idle_sdata_hi", frame_bits[31:0], 32'd0);
    check("idle_sdata_lo", frame_bits[63:32], 32'd0);
    check("idle_no_underrun", 32'(fs_underrun), 32'd0);

    // 2. Four pushes start RUN at the next frame.
    do_reset();
    for (int i = 0; i < 4; i++) push(32'h1234_5600 + 32'(i));
    check("t2_level4", 32'(fifo_level), 32'd4);
    capture_frame("t2f1");
    check("t2_level_after_pop", 32'(fs_level), 32'd3);
    check("t2_no_underrun", 32'(fs_underrun), 32'd0);
    check_frame("t2f1", 24'h123456);

    // 6. Async reset while the right slot is in progress.
    wait_edge(1, 600, n, found);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    check("rst_mid_outputs", {27'd0, i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underrun}, 32'd0);
    check("rst_mid_level", 32'(fifo_level), 32'd0);
    tick();
    rst = 1'b0;
    wait_edge(1, 400, n, found);
    check("rst_restart_lrclk", 32'(n), 32'd256);
    capture_frame("post_rst");
    check("post_rst_idle_no_ur", 32'(fs_underrun), 32'd0);
    check("post_rst_sdata", frame_bits[31:0] | frame_bits[63:32], 32'd0);

    // 3 + 5. Extreme values, then drain into underrun.
    do_reset();
    push(32'h8000_0000);
    push(32'h7FFF_FF00);
    push(32'h0000_0100);
    push(32'hFFFF_FF00);
    capture_frame("t3f1");
    check_frame("t3f1", 24'h800000);
    capture_frame("t3f2");
    check_frame("t3f2", 24'h7FFFFF);
    capture_frame("t3f3");
    check_frame("t3f3", 24'h000001);
    capture_frame("t3f4");
    check_frame("t3f4", 24'hFFFFFF);
    check("t3f4_no_underrun", 32'(fs_underrun), 32'd0);
    capture_frame("ur1");
    check("ur1_pulse", 32'(fs_underrun), 32'd1);
    check("ur1_one_clk", 32'(ur_after), 32'd0);
    check("ur1_sdata", frame_bits[31:0] | frame_bits[63:32], 32'd0);
    capture_frame("ur2");
    check("ur2_pulse", 32'(fs_underrun), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    check("ur_count", 32'(underrun_count), 32'd2);
`endif

    // 4. Nine back-to-back pushes in IDLE: the ninth is dropped.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sample_valid = 1'b1;
      audio_in = 32'h0101_0100 * 32'(i + 1);
      tick();
      check($sformatf("ovf_push%0d", i + 1), 32'(overflow), (i == 8) ? 32'd1 : 32'd0);
    end
    sample_valid = 1'b0;
    tick();
    check("ovf_one_clk", 32'(overflow), 32'd0);
    check("ovf_level", 32'(fifo_level), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
